// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers for the E stage.
// Optional divider support is enabled by defining MD_DIV_EN.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;

    // Products over the latched operands; sign-extension makes the low 64 bits the signed product
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

`ifdef MD_DIV_EN
    logic        div_signed;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Magnitude divide, then restore signs: quotient truncates to zero, remainder follows dividend
    assign div_signed = (op_q == OP_DIV);
    assign dvd_mag    = (div_signed && a_q[31]) ? -a_q : a_q;
    assign dvs_mag    = (div_signed && b_q[31]) ? -b_q : b_q;
    assign q_mag      = (b_q == '0) ? '0 : dvd_mag / dvs_mag;
    assign r_mag      = (b_q == '0) ? '0 : dvd_mag % dvs_mag;
    assign quot       = (div_signed && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
    assign rem        = (div_signed && a_q[31]) ? -r_mag : r_mag;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state: issue from IDLE only; any start during RUN is dropped
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            state_d = RUN;
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            op_d    = md_op;
                            a_d     = a;
                            b_d     = b;
                        end
`ifdef MD_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            state_d = RUN;
                            cnt_d   = CNT_W'(DIV_CYCLES - 1);
                            op_d    = md_op;
                            a_d     = a;
                            b_d     = b;
                        end
`endif
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
`ifdef MD_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            if (b_q != '0) begin
                                lo_d = quot;
                                hi_d = rem;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit; expectations follow the MD_DIV_EN build setting.
module tb_md_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_assert;
    int n_fail;
    int cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

`ifdef MD_DIV_EN
    localparam int DIV_EXP = 10;
`else
    localparam int DIV_EXP = 0;
`endif

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .md_op   (md_op),
        .a       (a_in),
        .b       (b_in),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue one op at the current negedge, then count busy cycles (bounded)
    task automatic run_md(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                          output int ncyc);
        start = 1'b1;
        md_op = op;
        a_in  = av;
        b_in  = bv;
        #1;
        check("busy_not_from_start", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        ncyc  = 0;
        while (busy && ncyc < 50) begin
            ncyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        md_op    = 3'd0;
        a_in     = '0;
        b_in     = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // mult -1 * 2
        run_md(3'd1, 32'hFFFF_FFFF, 32'd2, cycles);
        check("mult_busy_cycles", 32'(cycles), 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);

        // multu, back-to-back in the first idle cycle
        run_md(3'd2, 32'hFFFF_FFFF, 32'd2, cycles);
        check("multu_busy_cycles", 32'(cycles), 32'd5);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);
        exp_hi = 32'h0000_0001;
        exp_lo = 32'hFFFF_FFFE;

        // div -7 / 2
        run_md(3'd3, 32'hFFFF_FFF9, 32'd2, cycles);
`ifdef MD_DIV_EN
        exp_hi = 32'hFFFF_FFFF;
        exp_lo = 32'hFFFF_FFFD;
`endif
        check("div_busy_cycles", 32'(cycles), 32'(DIV_EXP));
        check("div_hi", hi, exp_hi);
        check("div_lo", lo, exp_lo);

        // divu 7 / 2
        run_md(3'd4, 32'd7, 32'd2, cycles);
`ifdef MD_DIV_EN
        exp_hi = 32'd1;
        exp_lo = 32'd3;
`endif
        check("divu_busy_cycles", 32'(cycles), 32'(DIV_EXP));
        check("divu_hi", hi, exp_hi);
        check("divu_lo", lo, exp_lo);

        // signed overflow case
        run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cycles);
`ifdef MD_DIV_EN
        exp_hi = 32'd0;
        exp_lo = 32'h8000_0000;
`endif
        check("divovf_busy_cycles", 32'(cycles), 32'(DIV_EXP));
        check("divovf_hi", hi, exp_hi);
        check("divovf_lo", lo, exp_lo);

        // mtlo then divide by zero leaves HI/LO alone
        run_md(3'd6, 32'h0000_1234, 32'd0, cycles);
        check("mtlo_busy_cycles", 32'(cycles), 32'd0);
        check("mtlo_lo", lo, 32'h0000_1234);
        exp_lo = 32'h0000_1234;
        run_md(3'd3, 32'd5, 32'd0, cycles);
        check("div0_busy_cycles", 32'(cycles), 32'(DIV_EXP));
        check("div0_hi", hi, exp_hi);
        check("div0_lo", lo, exp_lo);

        // mthi
        run_md(3'd5, 32'hDEAD_BEEF, 32'd0, cycles);
        check("mthi_busy_cycles", 32'(cycles), 32'd0);
        check("mthi_hi", hi, 32'hDEAD_BEEF);
        check("mthi_lo_kept", lo, exp_lo);

        // reserved op: no effect
        run_md(3'd7, 32'h1111_1111, 32'h2222_2222, cycles);
        check("rsvd_busy_cycles", 32'(cycles), 32'd0);
        check("rsvd_hi", hi, 32'hDEAD_BEEF);

        // starts during RUN are dropped
        start = 1'b1;
        md_op = 3'd1;
        a_in  = 32'd3;
        b_in  = 32'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        md_op = 3'd6;
        a_in  = 32'h55;
        @(negedge clk);
        md_op = 3'd1;
        a_in  = 32'd7;
        b_in  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        check("inflight_busy", 32'(busy), 32'd1);
        cycles = 0;
        while (busy && cycles < 50) begin
            cycles++;
            @(negedge clk);
        end
        check("inflight_remaining_cycles", 32'(cycles), 32'd2);
        check("inflight_hi", hi, 32'd0);
        check("inflight_lo", lo, 32'd12);

        // asynchronous reset in busy cycle 3
        run_md(3'd5, 32'hCAFE_F00D, 32'd0, cycles);
        start = 1'b1;
        md_op = 3'd1;
        a_in  = 32'hFFFF_FFFF;
        b_in  = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_reset_busy", 32'(busy), 32'd1);
        check("pre_reset_hi", hi, 32'hCAFE_F00D);
        reset_n = 1'b0;
        #1;
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_hi", hi, 32'd0);
        check("async_reset_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_hi", hi, 32'd0);
        check("post_reset_lo", lo, 32'd0);

        // unit still works after reset
        run_md(3'd2, 32'h0001_0000, 32'h0001_0000, cycles);
        check("multu2_busy_cycles", 32'(cycles), 32'd5);
        check("multu2_hi", hi, 32'd1);
        check("multu2_lo", lo, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
